decode_writeback: RTL and testbench
===================================

DECODE_WRITEBACK -- requirements
Module: decode_writeback

Interface
REQ-001 The block SHALL have the ports below; clock and reset come first.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- icode  in  4  instruction code from fetch split.
- rA  in  4  register ID from fetch align.
- rB  in  4  register ID from fetch align.
- cnd  in  1  condition result for cmovXX.
- valE  in  64  execute result to write back.
- valM  in  64  memory result to write back.
- wb_en  in  1  commit strobe; write-back occurs only on edges where it is high.
- dbg_sel  in  4  debug read register ID.
- srcA, srcB, dstE, dstM  out  4 each  decoded register IDs.
- valA, valB  out  64 each  register read data.
- dbg_val  out  64  debug read data.
- halted  out  1  sticky halt flag.
- ins_err  out  1  sticky invalid-instruction flag.

Function
REQ-002 The block SHALL hold 15 registers of 64 bits, with IDs 0x0 to 0xE; ID 0xF SHALL mean "none"; ID 0x4 SHALL be RSP.
REQ-003 srcA SHALL be rA for icode 2, 4, 6 or A; it SHALL be 0x4 for icode 9 or B; otherwise it SHALL be 0xF.
REQ-004 srcB SHALL be rB for icode 4, 5 or 6; it SHALL be 0x4 for icode 8, 9, A or B; otherwise it SHALL be 0xF.
REQ-005 dstE SHALL be rB for icode 3 or 6, and for icode 2 when cnd=1; it SHALL be 0xF for icode 2 when cnd=0; it SHALL be 0x4 for icode 8, 9, A or B; otherwise it SHALL be 0xF.
REQ-006 dstM SHALL be rA for icode 5 or B; otherwise it SHALL be 0xF.
REQ-007 valA, valB and dbg_val SHALL be combinational reads of srcA, srcB and dbg_sel; a read of ID 0xF SHALL return 0.
REQ-008 Reads SHALL return the value held before the current edge's write, with no bypass; the written value SHALL become visible in the cycle after the edge.
REQ-009 On a rising edge with wb_en=1, halted=0 and ins_err=0:
- if dstE≠0xF, register[dstE] SHALL be set to valE;
- if dstM≠0xF, register[dstM] SHALL be set to valM.
REQ-010 When dstE equals dstM and both are ≠0xF, valM SHALL win (popq %rsp semantics).
REQ-011 If icode=0 is committed (wb_en=1, with both flags clear at that edge), halted SHALL set on that edge.
REQ-012 If icode>0xB is committed the same way, ins_err SHALL set on that edge; no register SHALL be written for icode 0, 1, 7 or >0xB.
REQ-013 While halted=1 or ins_err=1, all register writes SHALL be suppressed, and both flags SHALL hold until reset.
REQ-014 Control states SHALL be RUN, HALT and ERR:
- RUN→HALT on a committed icode 0;
- RUN→ERR on a committed invalid icode;
- HALT and ERR SHALL be absorbing.
REQ-015 When wb_en=0, no state SHALL change.

Reset
REQ-016 When rst_n=0, all registers SHALL clear to 0 immediately, without waiting for clk, and state SHALL return to RUN (halted=0, ins_err=0).
REQ-017 Reset asserted in the same cycle as a write SHALL win; the register SHALL read 0 after reset.
REQ-018 Normal operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- irmovq: icode=3, rB=2, valE=0x1234, wb_en=1 for one edge → then icode=2 (cnd=1), rA=2: valA=0x1234; before the edge, valA through srcA=2 = 0.
- popq %rsp: icode=B, rA=4, valE=0x100, valM=0xDEAD, wb_en=1 → dbg_sel=4 reads 0xDEAD.
- cmovXX not taken: icode=2, cnd=0, rB=3, valE=5, wb_en=1 → dstE=0xF, register 3 unchanged at 0.
- halt: commit icode=0, then icode=3, rB=1, valE=7 → halted=1 and register 1 stays 0; assert rst_n=0 mid-cycle → halted=0 and all registers 0 without a clock edge.
- invalid instruction: commit icode=0xC → ins_err=1 and later writes are blocked; with wb_en=0, an icode=3 write never takes effect.
- read of ID 0xF: icode=1 → valA=valB=0, srcA=srcB=dstE=dstM=0xF.

Source files
------------

// File: rtl/decode_writeback.sv
// Register-file decode and write-back block for a Y86-64 style core.
// Ports: clk/rst_n; icode,rA,rB,cnd,valE,valM,wb_en in; dbg_sel in;
//        srcA,srcB,dstE,dstM,valA,valB,dbg_val,halted,ins_err out.
module decode_writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        wb_en,
  input  logic [3:0]  dbg_sel,
  output logic [3:0]  srcA,
  output logic [3:0]  srcB,
  output logic [3:0]  dstE,
  output logic [3:0]  dstM,
  output logic [63:0] valA,
  output logic [63:0] valB,
  output logic [63:0] dbg_val,
  output logic        halted,
  output logic        ins_err
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] R_RSP  = 4'h4;
  localparam logic [3:0] R_NONE = 4'hF;
  localparam int         NREG   = 15;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [63:0] rf_q [NREG];
  logic [63:0] rf_d [NREG];

  logic        commit;
  logic        we_e;
  logic        we_m;

  always_comb begin
    srcA = R_NONE;
    unique case (1'b1)
      (icode == I_RRMOVQ),
      (icode == I_RMMOVQ),
      (icode == I_OPQ),
      (icode == I_PUSHQ): srcA = rA;
      (icode == I_RET),
      (icode == I_POPQ):  srcA = R_RSP;
      default:            srcA = R_NONE;
    endcase
  end

  always_comb begin
    srcB = R_NONE;
    unique case (1'b1)
      (icode == I_RMMOVQ),
      (icode == I_MRMOVQ),
      (icode == I_OPQ):   srcB = rB;
      (icode == I_CALL),
      (icode == I_RET),
      (icode == I_PUSHQ),
      (icode == I_POPQ):  srcB = R_RSP;
      default:            srcB = R_NONE;
    endcase
  end

  // A not-taken conditional move drops its destination entirely.
  always_comb begin
    dstE = R_NONE;
    unique case (1'b1)
      (icode == I_RRMOVQ): dstE = cnd ? rB : R_NONE;
      (icode == I_IRMOVQ),
      (icode == I_OPQ):    dstE = rB;
      (icode == I_CALL),
      (icode == I_RET),
      (icode == I_PUSHQ),
      (icode == I_POPQ):   dstE = R_RSP;
      default:             dstE = R_NONE;
    endcase
  end

  always_comb begin
    dstM = R_NONE;
    unique case (1'b1)
      (icode == I_MRMOVQ),
      (icode == I_POPQ):  dstM = rA;
      default:            dstM = R_NONE;
    endcase
  end

  // Unused codes named for completeness of the decode map.
  logic unused_codes;
  assign unused_codes = (I_NOP == I_JXX);

  always_comb begin
    valA    = '0;
    valB    = '0;
    dbg_val = '0;
    for (int i = 0; i < NREG; i++) begin
      if (srcA == 4'(i))    valA    = rf_q[i];
      if (srcB == 4'(i))    valB    = rf_q[i];
      if (dbg_sel == 4'(i)) dbg_val = rf_q[i];
    end
  end

  assign commit = wb_en && (state_q == RUN);
  assign we_e   = commit && (dstE != R_NONE);
  assign we_m   = commit && (dstM != R_NONE);

  // M port applied last so popq %rsp keeps the loaded value.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      rf_d[i] = rf_q[i];
      if (we_e && (dstE == 4'(i))) rf_d[i] = valE;
      if (we_m && (dstM == 4'(i))) rf_d[i] = valM;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (commit && (icode == I_HALT))  state_d = HALT;
        else if (commit && (icode > I_POPQ)) state_d = ERR;
      end
      HALT:    state_d = HALT;
      ERR:     state_d = ERR;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NREG; i++) rf_q[i] <= rf_d[i];
    end
  end

  assign halted  = (state_q == HALT);
  assign ins_err = (state_q == ERR);

endmodule

// File: tb/tb_decode_writeback.sv
// Scoreboard bench for decode_writeback: directed vectors push expected
// values; a monitor pops and compares against the selected DUT output.
module tb_decode_writeback;

  logic        clk;
  logic        rst_n;
  logic [3:0]  icode;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_en;
  logic [3:0]  dbg_sel;
  logic [3:0]  srcA;
  logic [3:0]  srcB;
  logic [3:0]  dstE;
  logic [3:0]  dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic [63:0] dbg_val;
  logic        halted;
  logic        ins_err;

  decode_writeback dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .icode   (icode),
    .rA      (rA),
    .rB      (rB),
    .cnd     (cnd),
    .valE    (valE),
    .valM    (valM),
    .wb_en   (wb_en),
    .dbg_sel (dbg_sel),
    .srcA    (srcA),
    .srcB    (srcB),
    .dstE    (dstE),
    .dstM    (dstM),
    .valA    (valA),
    .valB    (valB),
    .dbg_val (dbg_val),
    .halted  (halted),
    .ins_err (ins_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {
    S_VALA, S_VALB, S_DBG, S_SRCA, S_SRCB,
    S_DSTE, S_DSTM, S_HALT, S_ERR
  } sel_t;

  typedef struct {
    string       name;
    sel_t        sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [63:0] pick(sel_t s);
    case (s)
      S_VALA:  return valA;
      S_VALB:  return valB;
      S_DBG:   return dbg_val;
      S_SRCA:  return 64'(srcA);
      S_SRCB:  return 64'(srcB);
      S_DSTE:  return 64'(dstE);
      S_DSTM:  return 64'(dstM);
      S_HALT:  return 64'(halted);
      default: return 64'(ins_err);
    endcase
  endfunction

  initial begin : monitor
    exp_t        e;
    logic [63:0] act;
    forever begin
      wait (sbq.size() > 0);
      e   = sbq.pop_front();
      act = pick(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
      end
    end
  end

  task automatic expect_v(input string n, input sel_t s, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.exp  = v;
    sbq.push_back(e);
    #0;
  endtask

  task automatic set_ins(input logic [3:0] ic, input logic [3:0] a,
                         input logic [3:0] b, input logic c,
                         input logic [63:0] e, input logic [63:0] m);
    icode = ic;
    rA    = a;
    rB    = b;
    cnd   = c;
    valE  = e;
    valM  = m;
  endtask

  // Drive at negedge, hold wb_en across exactly one rising edge.
  task automatic commit(input logic [3:0] ic, input logic [3:0] a,
                        input logic [3:0] b, input logic c,
                        input logic [63:0] e, input logic [63:0] m);
    @(negedge clk);
    set_ins(ic, a, b, c, e, m);
    wb_en = 1'b1;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    #1;
  endtask

  task automatic read_reg(input string n, input logic [3:0] id,
                          input logic [63:0] v);
    dbg_sel = id;
    #1;
    expect_v(n, S_DBG, v);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n   = 1'b0;
    wb_en   = 1'b0;
    dbg_sel = 4'hF;
    set_ins(4'h1, 4'hF, 4'hF, 1'b0, '0, '0);
    #12;
    expect_v("reset_halted", S_HALT, 64'd0);
    expect_v("reset_ins_err", S_ERR, 64'd0);
    read_reg("reset_r2", 4'h2, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // irmovq $0x1234,%rdx ; check no bypass before the edge
    @(negedge clk);
    set_ins(4'h3, 4'hF, 4'h2, 1'b0, 64'h1234, '0);
    dbg_sel = 4'h2;
    wb_en   = 1'b1;
    #1;
    expect_v("irmov_dstE", S_DSTE, 64'h2);
    expect_v("irmov_srcA", S_SRCA, 64'hF);
    expect_v("irmov_prewrite_r2", S_DBG, 64'd0);
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    set_ins(4'h2, 4'h2, 4'h5, 1'b1, '0, '0);
    #1;
    expect_v("rrmov_srcA", S_SRCA, 64'h2);
    expect_v("rrmov_valA", S_VALA, 64'h1234);
    expect_v("rrmov_dstE_taken", S_DSTE, 64'h5);

    // popq %rsp: M wins over E on the same register
    @(negedge clk);
    set_ins(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hDEAD);
    #1;
    expect_v("popq_srcA", S_SRCA, 64'h4);
    expect_v("popq_srcB", S_SRCB, 64'h4);
    expect_v("popq_dstE", S_DSTE, 64'h4);
    expect_v("popq_dstM", S_DSTM, 64'h4);
    commit(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'hDEAD);
    read_reg("popq_rsp", 4'h4, 64'hDEAD);

    // cmovXX not taken
    commit(4'h2, 4'h2, 4'h3, 1'b0, 64'd5, '0);
    expect_v("cmov_nt_dstE", S_DSTE, 64'hF);
    read_reg("cmov_nt_r3", 4'h3, 64'd0);

    // mrmovq 0(%rdx),%rsi
    commit(4'h5, 4'h6, 4'h2, 1'b0, 64'h77, 64'h55);
    expect_v("mrmov_srcB", S_SRCB, 64'h2);
    expect_v("mrmov_valB", S_VALB, 64'h1234);
    expect_v("mrmov_dstM", S_DSTM, 64'h6);
    read_reg("mrmov_r6", 4'h6, 64'h55);

    // OPq %rsi,%rdx
    @(negedge clk);
    set_ins(4'h6, 4'h6, 4'h2, 1'b0, '0, '0);
    #1;
    expect_v("opq_valA", S_VALA, 64'h55);
    expect_v("opq_valB", S_VALB, 64'h1234);
    expect_v("opq_dstE", S_DSTE, 64'h2);

    // wb_en low: nothing written
    @(negedge clk);
    set_ins(4'h3, 4'hF, 4'h7, 1'b0, 64'd9, '0);
    @(posedge clk);
    #1;
    read_reg("nowb_r7", 4'h7, 64'd0);

    // read of ID 0xF via nop
    @(negedge clk);
    set_ins(4'h1, 4'hF, 4'hF, 1'b0, '0, '0);
    dbg_sel = 4'hF;
    #1;
    expect_v("nop_srcA", S_SRCA, 64'hF);
    expect_v("nop_srcB", S_SRCB, 64'hF);
    expect_v("nop_dstE", S_DSTE, 64'hF);
    expect_v("nop_dstM", S_DSTM, 64'hF);
    expect_v("nop_valA", S_VALA, 64'd0);
    expect_v("nop_valB", S_VALB, 64'd0);
    expect_v("dbg_none", S_DBG, 64'd0);

    // halt, then a blocked write, then async reset mid-cycle
    commit(4'h0, 4'hF, 4'hF, 1'b0, '0, '0);
    expect_v("halt_set", S_HALT, 64'd1);
    commit(4'h3, 4'hF, 4'h1, 1'b0, 64'd7, '0);
    read_reg("halt_r1_blocked", 4'h1, 64'd0);
    expect_v("halt_sticky", S_HALT, 64'd1);
    read_reg("halt_r2_kept", 4'h2, 64'h1234);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_v("async_rst_halted", S_HALT, 64'd0);
    read_reg("async_rst_r2", 4'h2, 64'd0);
    read_reg("async_rst_r4", 4'h4, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    commit(4'h3, 4'hF, 4'h1, 1'b0, 64'd7, '0);
    read_reg("resume_r1", 4'h1, 64'd7);

    // invalid instruction
    commit(4'hC, 4'hF, 4'hF, 1'b0, '0, '0);
    expect_v("err_set", S_ERR, 64'd1);
    expect_v("err_not_halt", S_HALT, 64'd0);
    commit(4'h3, 4'hF, 4'h9, 1'b0, 64'd3, '0);
    read_reg("err_r9_blocked", 4'h9, 64'd0);
    @(negedge clk);
    set_ins(4'h3, 4'hF, 4'h9, 1'b0, 64'd4, '0);
    @(posedge clk);
    #1;
    read_reg("err_nowb_r9", 4'h9, 64'd0);
    commit(4'h0, 4'hF, 4'hF, 1'b0, '0, '0);
    expect_v("err_absorbing", S_HALT, 64'd0);
    expect_v("err_sticky", S_ERR, 64'd1);

    // reset wins over a same-cycle write
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    set_ins(4'h3, 4'hF, 4'h8, 1'b0, 64'hAA, '0);
    wb_en = 1'b1;
    @(posedge clk);
    #1;
    wb_en = 1'b0;
    rst_n = 1'b1;
    read_reg("rst_wins_r8", 4'h8, 64'd0);
    expect_v("rst_clears_err", S_ERR, 64'd0);

    for (int i = 0; i < 100 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d checks left unchecked, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
